tl_ul_responder: RTL and testbench
==================================

TL_UL_RESPONDER -- requirements
Module: tl_ul_responder

Interface
REQ-001 SHALL expose parameter ADDR_W, default 12, the channel A byte-address width.
REQ-002 SHALL expose parameter MEM_AW, default ADDR_W-2, the memory word-address width.
REQ-003 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 a_valid_i  input  1  channel A request valid.
REQ-006 a_ready_o  output  1  responder accepts channel A.
REQ-007 a_opcode_i  input  3  request opcode: 0 PutFullData, 1 PutPartialData, 4 Get.
REQ-008 a_address_i  input  ADDR_W  byte address.
REQ-009 a_size_i  input  2  log2 bytes: 0, 1 or 2.
REQ-010 a_mask_i  input  4  byte-lane enables.
REQ-011 a_data_i  input  32  write data.
REQ-012 d_valid_o  output  1  channel D response valid.
REQ-013 d_ready_i  input  1  initiator accepts channel D.
REQ-014 d_opcode_o  output  3  response opcode: 0 AccessAck, 1 AccessAckData.
REQ-015 d_size_o  output  2  echoes the request size.
REQ-016 d_error_o  output  1  request was rejected.
REQ-017 d_data_o  output  32  read data.
REQ-018 mem_req_o, mem_we_o  output  1 each  memory strobe and write enable.
REQ-019 mem_addr_o  output  MEM_AW  equals a_address_i[ADDR_W-1:2] of the latched request.
REQ-020 mem_wdata_o  output  32  write data; mem_wstrb_o  output  4  byte strobes.
REQ-021 mem_rdata_i  input  32  read data, valid the cycle after a read strobe.

Function
REQ-022 SHALL implement FSM states IDLE, MEM, RDATA, RESP.
REQ-023 a_ready_o SHALL be 1 exactly in IDLE; a request is accepted on a rising edge where a_valid_i and a_ready_o are both 1.
REQ-024 On acceptance, SHALL latch opcode, address, size, mask and data.
REQ-025 On acceptance, SHALL compute error = opcode not in {0,1,4}, or size=3, or size=1 with addr[0]=1, or size=2 with addr[1:0]!=0, or PutFullData with size=2 and mask!=4'hF, or a Put with mask=0.
REQ-026 Transitions: on acceptance, IDLE -> RESP if error, else IDLE -> MEM.
REQ-027 Transitions: MEM -> RDATA for Get; MEM -> RESP for Put.
REQ-028 Transitions: RDATA -> RESP unconditionally; RESP -> IDLE on d_valid_o && d_ready_i.
REQ-029 In MEM, mem_req_o SHALL be 1 for exactly one cycle, with mem_we_o=1 for Puts and 0 for Gets.
REQ-030 In MEM, mem_wstrb_o SHALL be the latched mask for Puts and 0 for Gets.
REQ-031 In RDATA, SHALL capture mem_rdata_i into the d_data_o register.
REQ-032 d_data_o SHALL be the full word for every Get size; lane selection is the initiator's job.
REQ-033 d_data_o SHALL be 0 for Put and error responses.
REQ-034 d_valid_o SHALL be 1 exactly in RESP, and all d_* outputs SHALL stay stable while d_valid_o=1 and d_ready_i=0.
REQ-035 d_opcode_o SHALL be 1 for Get (including errored Gets) and 0 otherwise; d_error_o SHALL be the latched error.
REQ-036 An errored request SHALL NOT assert mem_req_o.
REQ-037 Latency from the accept edge to first d_valid_o: Get 3 cycles, Put 2 cycles, error 1 cycle.
REQ-038 At most one transaction SHALL be outstanding, and no new request SHALL be accepted in the cycle its response completes.
REQ-039 mem_req_o SHALL be 0 outside MEM.

Reset
REQ-040 rst=1 SHALL immediately force state IDLE, including mid-transaction; a pending response is dropped and no memory strobe is issued.
REQ-041 Reset values: a_ready_o=1, d_valid_o=0, d_opcode_o=0, d_size_o=0, d_error_o=0, d_data_o=0.
REQ-042 Reset values: mem_req_o=0, mem_we_o=0, mem_wstrb_o=0, mem_addr_o=0, mem_wdata_o=0.

Structure
REQ-043 Package tl_pkg SHALL hold the A opcode enum (PutFullData, PutPartialData, Get), the D opcode enum (AccessAck, AccessAckData) and the size constants.
REQ-044 The FSM state enum SHALL be local to the module.
REQ-045 The legality check of REQ-025 SHALL be a combinational sub-module tl_a_check with output err_o.

Verification
REQ-046 Get addr 0x010, size 2, mask F, memory word 4 = 0xDEADBEEF, d_ready_i=1 -> mem_addr_o=4, mem_we_o=0, d_valid_o 3 cycles after accept, d_opcode_o=1, d_data_o=0xDEADBEEF, d_error_o=0.
REQ-047 PutPartialData addr 0x022, size 1, mask 4'b1100, data 0xABCD0000 -> one-cycle mem_req_o with mem_we_o=1, mem_wstrb_o=4'b1100, mem_addr_o=8; AccessAck 2 cycles after accept.
REQ-048 Get addr 0x003, size 2 -> d_error_o=1, d_opcode_o=1, no mem_req_o, response 1 cycle after accept.
REQ-049 Opcode 3 -> d_error_o=1, d_opcode_o=0, no mem_req_o.
REQ-050 Get with d_ready_i held 0 for 5 cycles -> d_* stable, a_ready_o=0 throughout; back-to-back a_valid_i accepted only on the cycle after the d handshake.
REQ-051 rst pulsed during MEM of a Put -> outputs at reset values immediately, no d_valid_o, next request served normally.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared TL-UL channel encodings for the single-beat responder.
package tl_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    Get            = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1
  } tl_d_op_e;

  localparam logic [1:0] SizeByte    = 2'd0;
  localparam logic [1:0] SizeHalf    = 2'd1;
  localparam logic [1:0] SizeWord    = 2'd2;
  localparam logic [1:0] SizeIllegal = 2'd3;

  localparam logic [3:0] MaskFull = 4'hF;
  localparam logic [3:0] MaskNone = 4'h0;

  function automatic logic is_put(input logic [2:0] op);
    return (op == PutFullData) || (op == PutPartialData);
  endfunction

  function automatic logic is_get(input logic [2:0] op);
    return op == Get;
  endfunction

endpackage

// File: rtl/tl_a_check.sv
// Combinational legality check of a channel A request (opcode, alignment, mask).
module tl_a_check
  import tl_pkg::*;
(
  input  logic [2:0] opcode_i,
  input  logic [1:0] addr_lo_i,
  input  logic [1:0] size_i,
  input  logic [3:0] mask_i,
  output logic       err_o
);

  logic op_ok;
  logic put;
  logic misaligned;
  logic full_mask_bad;
  logic empty_put;

  always_comb begin
    op_ok         = is_put(opcode_i) || is_get(opcode_i);
    put           = is_put(opcode_i);
    misaligned    = 1'b0;
    full_mask_bad = 1'b0;
    empty_put     = 1'b0;

    case (size_i)
      SizeByte: misaligned = 1'b0;
      SizeHalf: misaligned = addr_lo_i[0];
      SizeWord: misaligned = (addr_lo_i != 2'b00);
      default:  misaligned = 1'b1;
    endcase

    // A full-word PutFullData must write every lane.
    if ((opcode_i == PutFullData) && (size_i == SizeWord) && (mask_i != MaskFull)) begin
      full_mask_bad = 1'b1;
    end
    if (put && (mask_i == MaskNone)) begin
      empty_put = 1'b1;
    end

    err_o = !op_ok || misaligned || full_mask_bad || empty_put;
  end

endmodule

// File: rtl/tl_ul_responder.sv
// Single-outstanding TL-UL responder bridging channel A/D onto a simple SRAM-style port.
module tl_ul_responder
  import tl_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned MEM_AW = ADDR_W - 2
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [2:0]        a_opcode_i,
  input  logic [ADDR_W-1:0] a_address_i,
  input  logic [1:0]        a_size_i,
  input  logic [3:0]        a_mask_i,
  input  logic [31:0]       a_data_i,

  output logic              d_valid_o,
  input  logic              d_ready_i,
  output logic [2:0]        d_opcode_o,
  output logic [1:0]        d_size_o,
  output logic              d_error_o,
  output logic [31:0]       d_data_o,

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {
    StIdle,
    StMem,
    StRdata,
    StResp
  } state_e;

  state_e            state_q;
  logic              a_ready_q;
  logic              get_q;
  logic [MEM_AW-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              d_valid_q;
  logic [2:0]        d_opcode_q;
  logic [1:0]        d_size_q;
  logic              d_error_q;
  logic [31:0]       d_data_q;

  logic              mem_req_q;
  logic              mem_we_q;
  logic [3:0]        mem_wstrb_q;

  logic              a_err;

  tl_a_check u_a_check (
    .opcode_i  (a_opcode_i),
    .addr_lo_i (a_address_i[1:0]),
    .size_i    (a_size_i),
    .mask_i    (a_mask_i),
    .err_o     (a_err)
  );

  // All outputs are registered and updated alongside the state so that each
  // output is a clean function of the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_ready_q   <= 1'b1;
      get_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      d_valid_q   <= 1'b0;
      d_opcode_q  <= AccessAck;
      d_size_q    <= SizeByte;
      d_error_q   <= 1'b0;
      d_data_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= MaskNone;
    end else begin
      case (state_q)
        StIdle: begin
          if (a_valid_i) begin
            a_ready_q  <= 1'b0;
            get_q      <= is_get(a_opcode_i);
            addr_q     <= a_address_i[ADDR_W-1:2];
            wdata_q    <= a_data_i;
            d_opcode_q <= is_get(a_opcode_i) ? AccessAckData : AccessAck;
            d_size_q   <= a_size_i;
            d_error_q  <= a_err;
            d_data_q   <= '0;
            if (a_err) begin
              state_q   <= StResp;
              d_valid_q <= 1'b1;
            end else begin
              state_q     <= StMem;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_put(a_opcode_i);
              mem_wstrb_q <= is_put(a_opcode_i) ? a_mask_i : MaskNone;
            end
          end
        end

        StMem: begin
          mem_req_q   <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_wstrb_q <= MaskNone;
          if (get_q) begin
            state_q <= StRdata;
          end else begin
            state_q   <= StResp;
            d_valid_q <= 1'b1;
          end
        end

        StRdata: begin
          d_data_q  <= mem_rdata_i;
          d_valid_q <= 1'b1;
          state_q   <= StResp;
        end

        StResp: begin
          // The accept happens one cycle later, from IDLE, never on this edge.
          if (d_ready_i) begin
            d_valid_q <= 1'b0;
            a_ready_q <= 1'b1;
            state_q   <= StIdle;
          end
        end

        default: begin
          state_q     <= StIdle;
          a_ready_q   <= 1'b1;
          d_valid_q   <= 1'b0;
          mem_req_q   <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_wstrb_q <= MaskNone;
        end
      endcase
    end
  end

  assign a_ready_o   = a_ready_q;
  assign d_valid_o   = d_valid_q;
  assign d_opcode_o  = d_opcode_q;
  assign d_size_o    = d_size_q;
  assign d_error_o   = d_error_q;
  assign d_data_o    = d_data_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;

endmodule

// File: tb/tb_tl_ul_responder.sv
// Randomised and directed bench for tl_ul_responder against a transaction-level model.
module tb_tl_ul_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid_i;
  logic        a_ready_o;
  logic [2:0]  a_opcode_i;
  logic [11:0] a_address_i;
  logic [1:0]  a_size_i;
  logic [3:0]  a_mask_i;
  logic [31:0] a_data_i;
  logic        d_valid_o;
  logic        d_ready_i;
  logic [2:0]  d_opcode_o;
  logic [1:0]  d_size_o;
  logic        d_error_o;
  logic [31:0] d_data_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] dev_mem [1024];
  logic [31:0] ref_mem [1024];

  tl_ul_responder dut (
    .clk         (clk),
    .rst         (rst),
    .a_valid_i   (a_valid_i),
    .a_ready_o   (a_ready_o),
    .a_opcode_i  (a_opcode_i),
    .a_address_i (a_address_i),
    .a_size_i    (a_size_i),
    .a_mask_i    (a_mask_i),
    .a_data_i    (a_data_i),
    .d_valid_o   (d_valid_o),
    .d_ready_i   (d_ready_i),
    .d_opcode_o  (d_opcode_o),
    .d_size_o    (d_size_o),
    .d_error_o   (d_error_o),
    .d_data_o    (d_data_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wstrb_o (mem_wstrb_o),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM device: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wstrb_o[b]) dev_mem[mem_addr_o][8*b +: 8] = mem_wdata_o[8*b +: 8];
        end
      end else begin
        mem_rdata_i <= dev_mem[mem_addr_o];
      end
    end
  end

  function automatic bit ref_err(input int op, input int addr, input int size, input int mask);
    int nbytes;
    if (!(op == 0 || op == 1 || op == 4)) return 1'b1;
    if (size == 3) return 1'b1;
    nbytes = 1 << size;
    if ((addr % nbytes) != 0) return 1'b1;
    if (op != 4 && mask == 0) return 1'b1;
    if (op == 0 && size == 2 && mask != 15) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_txn(input logic [2:0] op, input logic [11:0] addr, input logic [1:0] size,
                         input logic [3:0] mask, input logic [31:0] data, input int stall,
                         input string name);
    bit          e;
    bit          get;
    int          lat_exp;
    int          k;
    bit          got;
    bit          rdy_seen;
    int          nreq;
    logic        we_c;
    logic [3:0]  st_c;
    logic [9:0]  ad_c;
    logic [31:0] wd_c;
    logic [31:0] exp_data;
    logic [37:0] snap;
    logic [37:0] now;
    e        = ref_err(int'(op), int'(addr), int'(size), int'(mask));
    get      = (op == 3'd4);
    lat_exp  = e ? 1 : (get ? 3 : 2);
    exp_data = (get && !e) ? ref_mem[addr[11:2]] : 32'h0;
    we_c = 1'b0; st_c = 4'h0; ad_c = '0; wd_c = '0;

    @(negedge clk);
    checks++;
    if (a_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s a_ready_before: got %b want 1", name, a_ready_o);
    end
    a_valid_i = 1'b1; a_opcode_i = op; a_address_i = addr; a_size_i = size;
    a_mask_i = mask; a_data_i = data; d_ready_i = 1'b0;
    @(posedge clk);
    #1 a_valid_i = 1'b0;

    k = 0; got = 1'b0; nreq = 0; rdy_seen = 1'b0;
    while (!got && k < 8) begin
      @(negedge clk);
      k++;
      if (a_ready_o) rdy_seen = 1'b1;
      if (mem_req_o) begin
        nreq++;
        we_c = mem_we_o; st_c = mem_wstrb_o; ad_c = mem_addr_o; wd_c = mem_wdata_o;
      end
      if (d_valid_o) got = 1'b1;
    end

    checks++;
    if (!got || k != lat_exp) begin
      errors++;
      $display("FAIL %s latency: got %0d (valid=%b) want %0d", name, k, got, lat_exp);
    end
    checks++;
    if (rdy_seen) begin
      errors++;
      $display("FAIL %s a_ready_busy: got 1 want 0", name);
    end
    checks++;
    if (nreq != (e ? 0 : 1)) begin
      errors++;
      $display("FAIL %s mem_req_count: got %0d want %0d", name, nreq, e ? 0 : 1);
    end
    if (!e) begin
      checks++;
      if (ad_c !== addr[11:2] || we_c !== !get || st_c !== (get ? 4'h0 : mask)) begin
        errors++;
        $display("FAIL %s mem_strobe: got addr=%h we=%b wstrb=%h want addr=%h we=%b wstrb=%h",
                 name, ad_c, we_c, st_c, addr[11:2], !get, get ? 4'h0 : mask);
      end
      if (!get) begin
        checks++;
        if (wd_c !== data) begin
          errors++;
          $display("FAIL %s mem_wdata: got %h want %h", name, wd_c, data);
        end
      end
    end
    checks++;
    if (d_opcode_o !== {2'b00, get} || d_size_o !== size || d_error_o !== e ||
        d_data_o !== exp_data) begin
      errors++;
      $display("FAIL %s d_fields: got op=%0d size=%0d err=%b data=%h want op=%0d size=%0d err=%b data=%h",
               name, d_opcode_o, d_size_o, d_error_o, d_data_o, get, size, e, exp_data);
    end

    if (!e && !get) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) ref_mem[addr[11:2]][8*b +: 8] = data[8*b +: 8];
      end
    end

    snap = {d_valid_o, a_ready_o, d_opcode_o, d_size_o, d_data_o};
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      now = {d_valid_o, a_ready_o, d_opcode_o, d_size_o, d_data_o};
      checks++;
      if (now !== snap || d_error_o !== e) begin
        errors++;
        $display("FAIL %s stall_stable cycle %0d: got %h want %h", name, s, now, snap);
      end
    end

    d_ready_i = 1'b1;
    @(negedge clk);
    d_ready_i = 1'b0;
    checks++;
    if (d_valid_o !== 1'b0 || a_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s after_handshake: got valid=%b ready=%b want valid=0 ready=1",
               name, d_valid_o, a_ready_o);
    end
  endtask

  task automatic test_reset();
    logic [87:0] obs;
    rst = 1'b1;
    a_valid_i = 1'b0; a_opcode_i = '0; a_address_i = '0; a_size_i = '0;
    a_mask_i = '0; a_data_i = '0; d_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    obs = {a_ready_o, d_valid_o, d_opcode_o, d_size_o, d_error_o, d_data_o,
           mem_req_o, mem_we_o, mem_wstrb_o, mem_addr_o, mem_wdata_o};
    checks++;
    if (obs !== {1'b1, 87'd0}) begin
      errors++;
      $display("FAIL reset_values: got %h want %h", obs, {1'b1, 87'd0});
    end
  endtask

  task automatic test_directed();
    dev_mem[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    run_txn(3'd4, 12'h010, 2'd2, 4'hF, 32'h0, 0, "get_deadbeef");
    run_txn(3'd1, 12'h022, 2'd1, 4'b1100, 32'hABCD0000, 0, "put_partial");
    run_txn(3'd4, 12'h020, 2'd2, 4'hF, 32'h0, 0, "get_after_put");
    run_txn(3'd4, 12'h003, 2'd2, 4'hF, 32'h0, 0, "get_misaligned");
    run_txn(3'd3, 12'h000, 2'd2, 4'hF, 32'h0, 0, "bad_opcode");
    run_txn(3'd0, 12'h030, 2'd2, 4'h7, 32'h11223344, 0, "putfull_partial_mask");
    run_txn(3'd1, 12'h034, 2'd0, 4'h0, 32'h55667788, 0, "put_empty_mask");
    run_txn(3'd4, 12'h001, 2'd3, 4'hF, 32'h0, 0, "size3");
  endtask

  task automatic test_stall();
    run_txn(3'd4, 12'h010, 2'd2, 4'hF, 32'h0, 5, "get_stall5");
  endtask

  task automatic test_back_to_back();
    int          k;
    bit          got;
    logic [31:0] exp2;
    exp2 = ref_mem[12'h044 >> 2];
    @(negedge clk);
    a_valid_i = 1'b1; a_opcode_i = 3'd4; a_address_i = 12'h040; a_size_i = 2'd2;
    a_mask_i = 4'hF; d_ready_i = 1'b0;
    @(posedge clk);
    #1 a_address_i = 12'h044;
    k = 0; got = 1'b0;
    while (!got && k < 8) begin
      @(negedge clk);
      k++;
      if (d_valid_o) got = 1'b1;
    end
    checks++;
    if (!got || d_data_o !== ref_mem[12'h040 >> 2]) begin
      errors++;
      $display("FAIL b2b_first: got valid=%b data=%h want valid=1 data=%h",
               got, d_data_o, ref_mem[12'h040 >> 2]);
    end
    d_ready_i = 1'b1;
    @(negedge clk);
    d_ready_i = 1'b0;
    checks++;
    if (a_ready_o !== 1'b1 || d_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_accept_on_handshake: got ready=%b valid=%b want ready=1 valid=0",
               a_ready_o, d_valid_o);
    end
    @(negedge clk);
    a_valid_i = 1'b0;
    checks++;
    if (a_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept_next: got ready=%b want 0", a_ready_o);
    end
    k = 1; got = 1'b0;
    while (!got && k < 8) begin
      @(negedge clk);
      k++;
      if (d_valid_o) got = 1'b1;
    end
    checks++;
    if (!got || k != 3 || d_data_o !== exp2) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d data=%h want lat=3 data=%h", k, d_data_o, exp2);
    end
    d_ready_i = 1'b1;
    @(negedge clk);
    d_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [87:0] obs;
    bit          seen;
    @(negedge clk);
    a_valid_i = 1'b1; a_opcode_i = 3'd0; a_address_i = 12'h080; a_size_i = 2'd2;
    a_mask_i = 4'hF; a_data_i = 32'hCAFEF00D; d_ready_i = 1'b1;
    @(posedge clk);
    #1 a_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_in_mem: got mem_req=%b want 1", mem_req_o);
    end
    rst = 1'b1;
    #1;
    obs = {a_ready_o, d_valid_o, d_opcode_o, d_size_o, d_error_o, d_data_o,
           mem_req_o, mem_we_o, mem_wstrb_o, mem_addr_o, mem_wdata_o};
    checks++;
    if (obs !== {1'b1, 87'd0}) begin
      errors++;
      $display("FAIL rst_mid_values: got %h want %h", obs, {1'b1, 87'd0});
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (d_valid_o) seen = 1'b1;
    end
    d_ready_i = 1'b0;
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_mid_no_response: got d_valid=1 want 0");
    end
    run_txn(3'd4, 12'h080, 2'd2, 4'hF, 32'h0, 1, "rst_mid_readback");
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [11:0] addr;
    logic [1:0]  size;
    logic [3:0]  mask;
    int          r;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      op = 3'd4;
      else if (r < 6) op = 3'd1;
      else if (r < 8) op = 3'd0;
      else            op = 3'($urandom_range(0, 7));
      size = ($urandom_range(0, 3) != 0) ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
      addr = 12'($urandom_range(0, 63));
      if (size != 2'd3 && $urandom_range(0, 3) != 0) begin
        addr = addr & ~12'((1 << size) - 1);
      end
      mask = 4'($urandom_range(0, 15));
      if (op == 3'd0 && size == 2'd2 && $urandom_range(0, 1) == 1) mask = 4'hF;
      run_txn(op, addr, size, mask, 32'($urandom), int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dev_mem[i] = $urandom;
      ref_mem[i] = dev_mem[i];
    end
    mem_rdata_i = '0;
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
